lsu_writeback: RTL and testbench
================================

Name: lsu_writeback

Overview:
- Memory/writeback end of the execute datapath.
- Consumes ALUResult (effective address or ALU value) and WriteData (store data) from execute, and performs byte/half/word loads and stores against a word-wide data memory using a request/ready handshake.
- Returns the 32-bit Result that execute writes back through WD3.
- Asserts Stall while a memory access is outstanding, so upstream holds its inputs.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width.
- ADDR_WIDTH, 32, memory address width.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- ALUResult  input  DATA_WIDTH  ALU output / effective address.
- WriteData  input  DATA_WIDTH  store data (rs2).
- PCPlus4  input  DATA_WIDTH  link value for JAL/JALR.
- funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MemRead  input  1  load request this cycle.
- MemWrite  input  1  store request this cycle.
- ResultSrc  input  2  00 ALU, 01 load data, 10 PCPlus4.
- Result  output  DATA_WIDTH  writeback value.
- RegWrite_ok  output  1  Result valid this cycle; gates WE3 upstream.
- Stall  output  1  hold upstream inputs.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- mem_wdata  output  DATA_WIDTH  lane-shifted store data.
- mem_wstrb  output  4  byte enables.
- mem_rdata  input  DATA_WIDTH  read data, valid with mem_ready.
- mem_ready  input  1  request accepted/completed this cycle.

Behaviour:
- Reset: state IDLE. Result = 0, RegWrite_ok = 0, Stall = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no MemRead/MemWrite:
  - Result is combinational from ResultSrc (ALU or PCPlus4); RegWrite_ok = 1; zero latency.
- IDLE, MemRead or MemWrite:
  - Latch address, size, sign, store data and op registers. Drive mem_* from the latched registers next cycle.
  - Go to ACCESS. Stall = 1 combinationally in this cycle.
- If MemRead and MemWrite are both 1, the store takes priority and the load is ignored.
- ACCESS:
  - mem_req = 1. All mem_* are held stable until mem_ready; Stall = 1.
  - On mem_ready, go to DONE. For loads, latch the extracted data.
- DONE:
  - Stall = 0. Loads: Result = latched load data, RegWrite_ok = 1. Stores: RegWrite_ok = 0.
  - Next cycle return to IDLE. Upstream advances on the Stall = 0 edge.
- Load latency = 2 + memory wait cycles (mem_ready in the first ACCESS cycle gives 3 clocks IDLE→DONE→IDLE).
- Store lane rules, with off = addr[1:0]:
  - B: wstrb = 0001 << off; wdata = {4{WriteData[7:0]}}.
  - H: wstrb = 0011 << (off[1]*2); wdata = {2{WriteData[15:0]}}.
  - W: wstrb = 1111; wdata = WriteData.
- Load extract: select byte/half by off, then sign-extend (B, H) or zero-extend (BU, HU). W passes through.
- Misaligned addresses (feature off): H uses off[1] only; W ignores off. The access is always performed.
- Reset mid-ACCESS: return to IDLE immediately, mem_req drops the same edge, and no writeback occurs. The memory must tolerate an abandoned request.
- funct3 undefined (011, 110, 111): treated as W.
- mem_ready while not in ACCESS: ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - Misaligned request means H with off[0] = 1, or W with off != 0.
  - For a misaligned request: no memory access; FSM goes IDLE→DONE directly; misalign = 1 for the DONE cycle; RegWrite_ok = 0 for loads too.
- Undefined: no misalign port; the alignment rules above apply.

Test Plan:
- ALU path: MemRead = MemWrite = 0, ResultSrc = 00, ALUResult = 0x1234 -> Result = 0x1234, RegWrite_ok = 1, Stall = 0 in the same cycle; ResultSrc = 10, PCPlus4 = 0x104 -> Result = 0x104.
- Store byte: ALUResult = 0x102, WriteData = 0xAABBCCDD, funct3 = 000 -> mem_addr = 0x100, mem_wstrb = 0100, mem_wdata = 0xDDDDDDDD, mem_we = 1; Stall = 1 until mem_ready.
- Signed load: mem_rdata = 0x80FF0000, ALUResult = 0x202, funct3 = 001 -> Result = 0xFFFF80FF. Same with funct3 = 101 -> 0x000080FF.
- Wait states: mem_ready delayed 4 cycles -> mem_req/mem_addr held constant, Stall = 1 throughout, DONE exactly 1 cycle after mem_ready.
- Reset during ACCESS: assert rst with mem_ready = 0 -> next edge IDLE, mem_req = 0, RegWrite_ok = 0, no Result update.
- With LSU_MISALIGN_TRAP_EN: LW at 0x101 -> mem_req never asserted, misalign = 1 for one cycle, RegWrite_ok = 0.

Source files
------------

// File: rtl/lsu_writeback.sv
// Load/store writeback stage: byte/half/word accesses over a req/ready memory port.
// Optional misaligned-access trap is enabled with `define LSU_MISALIGN_TRAP_EN.
//
// state  | meaning
// IDLE   | ALU/link writeback at zero latency, or latch a memory op
// ACCESS | mem_req held until mem_ready
// DONE   | one-cycle writeback of load data (or store/trap completion)
module lsu_writeback #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [DATA_WIDTH-1:0] PCPlus4,
   input  logic [2:0]            funct3,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [1:0]            ResultSrc,
   output logic [DATA_WIDTH-1:0] Result,
   output logic                  RegWrite_ok,
   output logic                  Stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
`ifdef LSU_MISALIGN_TRAP_EN
   ,
   output logic                  misalign
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]            state;
   logic                  req;
   logic [1:0]            off;
   logic                  misaligned_req;
   logic [3:0]            st_strb;
   logic [DATA_WIDTH-1:0] st_data;
   logic [DATA_WIDTH-1:0] alu_mux;

   logic [2:0]            f3_q;
   logic [1:0]            off_q;
   logic                  load_op_q;
   logic                  misalign_q;
   logic [DATA_WIDTH-1:0] load_q;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_data;

   assign req     = MemRead | MemWrite;
   assign off     = ALUResult[1:0];
   assign alu_mux = (ResultSrc == 2'b10) ? PCPlus4 : ALUResult;
   assign mem_req = (state == ACCESS);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned_req = ((funct3[1:0] == 2'b01) && off[0]) ||
                           (funct3[1] && (off != 2'b00));
   assign misalign       = misalign_q;
`else
   assign misaligned_req = 1'b0;
`endif

   // funct3[1:0]: 00 byte, 01 half, 1x word (covers the undefined encodings)
   always_comb begin
      st_strb = 4'b1111;
      st_data = WriteData;
      case (funct3[1:0])
         2'b00: begin
            st_strb = 4'b0001 << off;
            st_data = {4{WriteData[7:0]}};
         end
         2'b01: begin
            st_strb = off[1] ? 4'b1100 : 4'b0011;
            st_data = {2{WriteData[15:0]}};
         end
         default: begin
            st_strb = 4'b1111;
            st_data = WriteData;
         end
      endcase
   end

   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (off_q)
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
         3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
         3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= 4'b0000;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
         load_op_q  <= 1'b0;
         misalign_q <= 1'b0;
         load_q     <= '0;
      end else begin
         misalign_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  // store wins when both MemRead and MemWrite are set
                  mem_we    <= MemWrite;
                  mem_addr  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                  mem_wdata <= st_data;
                  mem_wstrb <= MemWrite ? st_strb : 4'b0000;
                  f3_q      <= funct3;
                  off_q     <= off;
                  load_op_q <= ~MemWrite;
                  if (misaligned_req) begin
                     state      <= DONE;
                     misalign_q <= 1'b1;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  state <= DONE;
                  if (load_op_q) load_q <= ld_data;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // outputs forced quiet while reset is held so nothing writes back
   always_comb begin
      Result      = '0;
      RegWrite_ok = 1'b0;
      Stall       = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               Result      = alu_mux;
               Stall       = req;
               RegWrite_ok = ~req;
            end
            ACCESS: Stall = 1'b1;
            DONE: begin
               Result      = load_op_q ? load_q : alu_mux;
               RegWrite_ok = load_op_q & ~misalign_q;
            end
            default: begin
               Result      = '0;
               RegWrite_ok = 1'b0;
               Stall       = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_writeback.sv
// Directed self-checking bench for lsu_writeback; define LSU_MISALIGN_TRAP_EN
// on both files to exercise the trap path.
module tb_lsu_writeback;

   logic        clk;
   logic        rst;
   logic [31:0] ALUResult, WriteData, PCPlus4;
   logic [2:0]  funct3;
   logic        MemRead, MemWrite;
   logic [1:0]  ResultSrc;
   logic [31:0] Result;
   logic        RegWrite_ok, Stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int passed = 0;
   int total  = 0;

   lsu_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ALUResult(ALUResult), .WriteData(WriteData), .PCPlus4(PCPlus4),
      .funct3(funct3), .MemRead(MemRead), .MemWrite(MemWrite),
      .ResultSrc(ResultSrc), .Result(Result), .RegWrite_ok(RegWrite_ok),
      .Stall(Stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
`ifdef LSU_MISALIGN_TRAP_EN
      , .misalign(misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; ALUResult = 32'h0; WriteData = 32'h0; PCPlus4 = 32'h0;
      funct3 = 3'b000; MemRead = 1'b0; MemWrite = 1'b0; ResultSrc = 2'b00;
      mem_rdata = 32'h0; mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      ALUResult = 32'h1111; PCPlus4 = 32'h2222;
      #1;
      total++; if (Result !== 32'h0) $display("FAIL reset_result got %h exp %h", Result, 32'h0); else passed++;
      total++; if (RegWrite_ok !== 1'b0) $display("FAIL reset_regwrite got %b exp 0", RegWrite_ok); else passed++;
      total++; if (Stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", Stall); else passed++;
      total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_req_we got %b%b exp 00", mem_req, mem_we); else passed++;
      total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0)
         $display("FAIL reset_mem_bus got %h/%h/%b exp 0/0/0", mem_addr, mem_wdata, mem_wstrb); else passed++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_alu_path();
      ALUResult = 32'h1234; PCPlus4 = 32'h104; ResultSrc = 2'b00;
      #1;
      total++; if (Result !== 32'h1234) $display("FAIL alu_result got %h exp %h", Result, 32'h1234); else passed++;
      total++; if (RegWrite_ok !== 1'b1 || Stall !== 1'b0)
         $display("FAIL alu_flags got ok=%b stall=%b exp ok=1 stall=0", RegWrite_ok, Stall); else passed++;
      ResultSrc = 2'b10;
      #1;
      total++; if (Result !== 32'h104) $display("FAIL link_result got %h exp %h", Result, 32'h104); else passed++;
      @(negedge clk);
      ResultSrc = 2'b00;
   endtask

   // drives one store (optionally with MemRead also set) and checks the bus
   task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3, input logic also_rd,
                            input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input int waits);
      ALUResult = addr; WriteData = data; funct3 = f3;
      MemWrite = 1'b1; MemRead = also_rd; ResultSrc = 2'b00; mem_ready = 1'b0;
      #1;
      total++; if (Stall !== 1'b1 || RegWrite_ok !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL st_issue got stall=%b ok=%b req=%b exp 1/0/0", Stall, RegWrite_ok, mem_req); else passed++;
      @(negedge clk);
      for (int i = 0; i <= waits; i++) begin
         total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || Stall !== 1'b1)
            $display("FAIL st_access got req=%b we=%b stall=%b exp 1/1/1", mem_req, mem_we, Stall); else passed++;
         total++; if (mem_addr !== exp_addr || mem_wstrb !== exp_strb || mem_wdata !== exp_wdata)
            $display("FAIL st_bus got %h/%b/%h exp %h/%b/%h", mem_addr, mem_wstrb, mem_wdata,
                     exp_addr, exp_strb, exp_wdata); else passed++;
         if (i == waits) mem_ready = 1'b1;
         @(negedge clk);
      end
      total++; if (Stall !== 1'b0 || RegWrite_ok !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL st_done got stall=%b ok=%b req=%b exp 0/0/0", Stall, RegWrite_ok, mem_req); else passed++;
      MemWrite = 1'b0; MemRead = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      #1;
      total++; if (Stall !== 1'b0 || RegWrite_ok !== 1'b1 || mem_req !== 1'b0)
         $display("FAIL st_idle got stall=%b ok=%b req=%b exp 0/1/0", Stall, RegWrite_ok, mem_req); else passed++;
   endtask

   task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_res, input int waits);
      ALUResult = addr; funct3 = f3; MemRead = 1'b1; MemWrite = 1'b0;
      ResultSrc = 2'b01; mem_ready = 1'b0; mem_rdata = 32'h0BAD0BAD;
      #1;
      total++; if (Stall !== 1'b1 || RegWrite_ok !== 1'b0)
         $display("FAIL ld_issue got stall=%b ok=%b exp 1/0", Stall, RegWrite_ok); else passed++;
      @(negedge clk);
      // inputs wiggle while stalled; the latched request must not move
      ALUResult = ~addr; funct3 = ~f3;
      for (int i = 0; i <= waits; i++) begin
         total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || Stall !== 1'b1 || mem_addr !== exp_addr)
            $display("FAIL ld_access got req=%b we=%b stall=%b addr=%h exp 1/0/1/%h",
                     mem_req, mem_we, Stall, mem_addr, exp_addr); else passed++;
         if (i == waits) begin
            mem_ready = 1'b1; mem_rdata = rdata;
         end
         @(negedge clk);
      end
      mem_rdata = 32'h0BAD0BAD; mem_ready = 1'b0;
      #1;
      total++; if (Result !== exp_res) $display("FAIL ld_result got %h exp %h", Result, exp_res); else passed++;
      total++; if (RegWrite_ok !== 1'b1 || Stall !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL ld_done got ok=%b stall=%b req=%b exp 1/0/0", RegWrite_ok, Stall, mem_req); else passed++;
      MemRead = 1'b0; ResultSrc = 2'b00; ALUResult = 32'h00C0FFEE;
      @(negedge clk);
      #1;
      total++; if (Result !== 32'h00C0FFEE || Stall !== 1'b0 || RegWrite_ok !== 1'b1)
         $display("FAIL ld_idle got res=%h stall=%b ok=%b exp 00c0ffee/0/1", Result, Stall, RegWrite_ok); else passed++;
   endtask

   task automatic test_stores();
      run_store(32'h102, 32'hAABBCCDD, 3'b000, 1'b0, 32'h100, 4'b0100, 32'hDDDDDDDD, 1);
      run_store(32'h206, 32'h11223344, 3'b001, 1'b0, 32'h204, 4'b1100, 32'h33443344, 0);
      run_store(32'h30C, 32'h01020304, 3'b010, 1'b0, 32'h30C, 4'b1111, 32'h01020304, 0);
   endtask

   task automatic test_store_priority();
      run_store(32'h401, 32'h0000005A, 3'b000, 1'b1, 32'h400, 4'b0010, 32'h5A5A5A5A, 0);
   endtask

   task automatic test_loads();
      run_load(32'h202, 3'b001, 32'h80FF0000, 32'h200, 32'hFFFF80FF, 0);
      run_load(32'h202, 3'b101, 32'h80FF0000, 32'h200, 32'h000080FF, 0);
      run_load(32'h203, 3'b000, 32'h80FF0000, 32'h200, 32'hFFFFFF80, 0);
      run_load(32'h202, 3'b100, 32'h80FF0000, 32'h200, 32'h000000FF, 0);
      run_load(32'h300, 3'b010, 32'hDEADBEEF, 32'h300, 32'hDEADBEEF, 0);
      run_load(32'h308, 3'b011, 32'h12345678, 32'h308, 32'h12345678, 0);
   endtask

   task automatic test_wait_states();
      run_load(32'h500, 3'b010, 32'h55AA55AA, 32'h500, 32'h55AA55AA, 4);
      run_store(32'h503, 32'h000000C3, 3'b000, 1'b0, 32'h500, 4'b1000, 32'hC3C3C3C3, 3);
   endtask

   task automatic test_back_to_back();
      run_load(32'h600, 3'b001, 32'h00017FFF, 32'h600, 32'h00007FFF, 0);
      run_load(32'h604, 3'b000, 32'h0000007F, 32'h604, 32'h0000007F, 0);
   endtask

   task automatic test_ready_idle();
      mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF; ALUResult = 32'h77;
      #1;
      total++; if (Result !== 32'h77 || RegWrite_ok !== 1'b1 || Stall !== 1'b0)
         $display("FAIL ready_idle got res=%h ok=%b stall=%b exp 77/1/0", Result, RegWrite_ok, Stall); else passed++;
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || Stall !== 1'b0)
         $display("FAIL ready_idle_next got req=%b stall=%b exp 0/0", mem_req, Stall); else passed++;
      mem_ready = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      ALUResult = 32'h404; funct3 = 3'b010; MemRead = 1'b1; ResultSrc = 2'b01; mem_ready = 1'b0;
      @(negedge clk);
      total++; if (mem_req !== 1'b1) $display("FAIL rst_mid_pre got req=%b exp 1", mem_req); else passed++;
      rst = 1'b1; mem_rdata = 32'h99999999;
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || RegWrite_ok !== 1'b0 || Stall !== 1'b0 || Result !== 32'h0)
         $display("FAIL rst_mid got req=%b ok=%b stall=%b res=%h exp 0/0/0/0",
                  mem_req, RegWrite_ok, Stall, Result); else passed++;
      rst = 1'b0; MemRead = 1'b0; ResultSrc = 2'b00; ALUResult = 32'h55;
      mem_ready = 1'b1;
      #1;
      total++; if (Result !== 32'h55 || RegWrite_ok !== 1'b1 || Stall !== 1'b0)
         $display("FAIL rst_mid_after got res=%h ok=%b stall=%b exp 55/1/0", Result, RegWrite_ok, Stall); else passed++;
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || Stall !== 1'b0 || Result !== 32'h55)
         $display("FAIL rst_mid_next got req=%b stall=%b res=%h exp 0/0/55", mem_req, Stall, Result); else passed++;
      mem_ready = 1'b0;
   endtask

`ifdef LSU_MISALIGN_TRAP_EN
   task automatic test_misalign();
      ALUResult = 32'h101; funct3 = 3'b010; MemRead = 1'b1; ResultSrc = 2'b01; mem_ready = 1'b0;
      #1;
      total++; if (Stall !== 1'b1 || misalign !== 1'b0)
         $display("FAIL mis_issue got stall=%b mis=%b exp 1/0", Stall, misalign); else passed++;
      @(negedge clk);
      total++; if (misalign !== 1'b1 || mem_req !== 1'b0 || RegWrite_ok !== 1'b0 || Stall !== 1'b0)
         $display("FAIL mis_done got mis=%b req=%b ok=%b stall=%b exp 1/0/0/0",
                  misalign, mem_req, RegWrite_ok, Stall); else passed++;
      MemRead = 1'b0; ResultSrc = 2'b00;
      @(negedge clk);
      total++; if (misalign !== 1'b0 || mem_req !== 1'b0 || RegWrite_ok !== 1'b1)
         $display("FAIL mis_after got mis=%b req=%b ok=%b exp 0/0/1", misalign, mem_req, RegWrite_ok); else passed++;
   endtask
`else
   task automatic test_misalign();
      run_load(32'h201, 3'b001, 32'h1234ABCD, 32'h200, 32'hFFFFABCD, 0);
      run_load(32'h103, 3'b010, 32'hCAFEF00D, 32'h100, 32'hCAFEF00D, 0);
      run_store(32'h203, 32'h11223344, 3'b001, 1'b0, 32'h200, 4'b1100, 32'h33443344, 0);
   endtask
`endif

   initial begin
      test_reset();
      test_alu_path();
      test_stores();
      test_store_priority();
      test_loads();
      test_wait_states();
      test_back_to_back();
      test_ready_idle();
      test_misalign();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
